mpi_noc_out_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares one NoC output port (flit/last/valid/ready)

---
 rtl/mpi_noc_out_arbiter_if.sv | 25 ++
 rtl/mpi_noc_out_arbiter.sv | 105 ++++++++++
 tb/tb_mpi_noc_out_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpi_noc_out_arbiter_if.sv
// Shared NoC output port bundle: per-requester flit/last/valid/ready plus the single outbound link.
// The master modport is the arbiter's view; the slave modport is the requester/NoC side.
interface mpi_noc_out_arbiter_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 4
);
  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]            in_last;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [FLIT_WIDTH-1:0]          out_flit;
  logic                           out_last;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  modport slave (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/mpi_noc_out_arbiter.sv
// Packet-level round-robin arbiter for one NoC output: 1-cycle arbitration, then zero-latency pass-through.
// Backpressure: out_ready is forwarded only to the granted requester; the grant is held until its last flit is accepted.
module mpi_noc_out_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mpi_noc_out_arbiter_if.master bus,
  output logic [CHANNELS-1:0]  grant,
  output logic                 busy
);
  localparam int PW = $clog2(CHANNELS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        g_idx;
  logic [PW-1:0]        ptr_next;
  logic                 pick_vld;
  logic [CHANNELS-1:0]  hi_mask;
  logic [CHANNELS-1:0]  req_hi;
  logic [FLIT_WIDTH-1:0] mux_flit;
  logic                 mux_last;
  logic                 mux_valid;
  logic                 active;
  logic                 xfer;

  // Requests at or above the pointer win over wrapped-around ones.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hi_mask[i] = (PW'(i) >= rr_ptr);
    end
  end

  assign req_hi   = bus.in_valid & hi_mask;
  assign pick_vld = |bus.in_valid;

  always_comb begin
    pick_idx = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (bus.in_valid[i]) pick_idx = PW'(i);
    end
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (req_hi[i]) pick_idx = PW'(i);
    end
  end

  // Grant is one-hot or zero, so an OR-mux selects the owner without a decoder.
  always_comb begin
    g_idx     = '0;
    mux_flit  = '0;
    mux_last  = 1'b0;
    mux_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        g_idx     = g_idx | PW'(i);
        mux_flit  = mux_flit | bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        mux_last  = mux_last | bus.in_last[i];
        mux_valid = mux_valid | bus.in_valid[i];
      end
    end
  end

  assign ptr_next = (g_idx == PW'(CHANNELS-1)) ? '0 : g_idx + PW'(1);

  assign active        = (state == ACTIVE);
  assign busy          = active;
  assign bus.out_flit  = active ? mux_flit : '0;
  assign bus.out_last  = active & mux_last;
  assign bus.out_valid = active & mux_valid;
  assign bus.in_ready  = active ? (grant & {CHANNELS{bus.out_ready}}) : '0;
  assign xfer          = active & mux_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= CHANNELS'(1) << pick_idx;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (xfer && mux_last) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= ptr_next;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mpi_noc_out_arbiter.sv
// Directed and constrained-random bench for the packet round-robin NoC output arbiter.
module tb_mpi_noc_out_arbiter;
  localparam int FW = 32;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] grant;
  logic          busy;
  int            checks = 0;
  int            failures = 0;

  mpi_noc_out_arbiter_if #(.FLIT_WIDTH(FW), .CHANNELS(CH)) bus ();

  mpi_noc_out_arbiter #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.master),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int c, input logic v, input logic l, input logic [FW-1:0] f);
    bus.in_valid[c]          = v;
    bus.in_last[c]           = l;
    bus.in_flit[c*FW +: FW]  = f;
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit t4_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit t4_vld [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int t4_idx [7] = '{0, 1, 1, 1, 1, 2, 3};
  logic [FW-1:0] got [$];

  int len [CH];
  int pos [CH];
  int pkt [CH];
  int wait_pk [CH];
  bit vld [CH];
  int exp_pos [CH];
  int exp_pkt [CH];
  int owner;
  int ch;
  int ntx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_flit   = '0;
    bus.in_last   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;

    // Reset with every requester asking: outputs must clear immediately.
    @(negedge clk);
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_flit", bus.out_flit, 0);
    @(negedge clk);
    #1;
    check("rst_hold_grant", grant, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = '0;

    // Single 3-flit packet on ch2.
    drive(2, 1'b1, 1'b0, 32'hA0);
    bus.out_ready = 1'b1;
    #1;
    check("t2_arb_grant", grant, 0);
    check("t2_arb_out_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    check("t2_grant", grant, 4'b0100);
    check("t2_busy", busy, 1);
    check("t2_f0", bus.out_flit, 32'hA0);
    check("t2_f0_valid", bus.out_valid, 1);
    check("t2_in_ready", bus.in_ready, 4'b0100);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'hA1);
    #1;
    check("t2_f1", bus.out_flit, 32'hA1);
    check("t2_f1_last", bus.out_last, 0);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'hA2);
    #1;
    check("t2_f2", bus.out_flit, 32'hA2);
    check("t2_f2_last", bus.out_last, 1);
    check("t2_f2_busy", busy, 1);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0);
    #1;
    check("t2_end_busy", busy, 0);
    check("t2_end_grant", grant, 0);
    check("t2_rr_ptr", dut.rr_ptr, 3);
    @(negedge clk);

    // Round-robin over 1-flit packets from reset: 0,1,2,3,0 with a bubble each.
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < CH; c++) drive(c, 1'b1, 1'b1, 32'hC0 + c);
    for (int n = 0; n < 5; n++) begin
      #1;
      check($sformatf("t3_bubble%0d_valid", n), bus.out_valid, 0);
      check($sformatf("t3_bubble%0d_rdy", n), bus.in_ready, 0);
      @(negedge clk);
      #1;
      check($sformatf("t3_pkt%0d_grant", n), grant, 4'b0001 << (n % 4));
      check($sformatf("t3_pkt%0d_rdy", n), bus.in_ready, 4'b0001 << (n % 4));
      check($sformatf("t3_pkt%0d_flit", n), bus.out_flit, 32'hC0 + (n % 4));
      @(negedge clk);
    end
    bus.in_valid = '0;

    // rr_ptr is now 1: ch1 4-flit packet with stalls and a valid hole, ch0/ch3 waiting.
    drive(1, 1'b1, 1'b0, 32'hB0);
    drive(0, 1'b1, 1'b1, 32'hD0);
    drive(3, 1'b1, 1'b1, 32'hD3);
    bus.out_ready = 1'b1;
    #1;
    check("t4_arb_grant", grant, 0);
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      bus.out_ready = t4_rdy[k];
      drive(1, t4_vld[k], t4_idx[k] == 3, 32'hB0 + t4_idx[k]);
      #1;
      check($sformatf("t4_c%0d_grant", k), grant, 4'b0010);
      check($sformatf("t4_c%0d_valid", k), bus.out_valid, t4_vld[k]);
      check($sformatf("t4_c%0d_rdy", k), bus.in_ready, t4_rdy[k] ? 4'b0010 : 4'b0000);
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_flit);
      @(negedge clk);
    end
    check("t4_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_order%0d", i), (got.size() > i) ? got[i] : 32'hX, 32'hB0 + i);
    end
    drive(1, 1'b0, 1'b0, 32'h0);
    #1;
    check("t4_bubble", grant, 0);
    @(negedge clk);
    #1;
    check("t4_next_grant", grant, 4'b1000);
    check("t4_next_flit", bus.out_flit, 32'hD3);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 32'h0);
    #1;
    check("t4_bubble2", grant, 0);
    @(negedge clk);
    #1;
    check("t4_last_grant", grant, 4'b0001);
    check("t4_last_flit", bus.out_flit, 32'hD0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a ch3 packet; ch0 must win afterwards.
    drive(3, 1'b1, 1'b0, 32'hE0);
    bus.out_ready = 1'b1;
    #1;
    @(negedge clk);
    #1;
    check("t5_f0", bus.out_flit, 32'hE0);
    check("t5_grant", grant, 4'b1000);
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'hE1);
    #1;
    check("t5_f1", bus.out_flit, 32'hE1);
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'hE2);
    drive(0, 1'b1, 1'b1, 32'hF0);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rdy", bus.in_ready, 0);
    check("t5_rst_flit", bus.out_flit, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_idle_grant", grant, 0);
    @(negedge clk);
    #1;
    check("t5_after_grant", grant, 4'b0001);
    check("t5_after_flit", bus.out_flit, 32'hF0);
    @(negedge clk);

    // Random traffic with per-channel sequence tracking and fairness bound.
    do_reset();
    for (int c = 0; c < CH; c++) begin
      len[c] = 1 + $urandom_range(0, 3);
      pos[c] = 0;
      pkt[c] = 0;
      vld[c] = 1'b0;
      wait_pk[c] = 0;
      exp_pos[c] = 0;
      exp_pkt[c] = 0;
    end
    owner = -1;
    ntx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (pos[c] == 0) begin
          if (!vld[c]) vld[c] = ($urandom_range(0, 2) == 0);
        end else begin
          vld[c] = ($urandom_range(0, 3) != 0);
        end
        drive(c, vld[c], pos[c] == len[c] - 1, {4'(c), 12'(pkt[c]), 8'(pos[c]), 8'(len[c])});
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("r_onehot", $onehot0(grant), 1);
      check("r_in_ready", bus.in_ready, bus.out_ready ? grant : 4'b0000);
      if (bus.out_valid && bus.out_ready) begin
        ntx++;
        ch = int'(bus.out_flit[31:28]);
        check("r_chan_range", ch < CH, 1);
        if (ch < CH) begin
          check("r_grant_owner", grant, 4'b0001 << ch);
          if (owner >= 0) check("r_interleave", ch, owner);
          check("r_seq", bus.out_flit[27:8], {12'(exp_pkt[ch]), 8'(exp_pos[ch])});
          check("r_last", bus.out_last, bus.out_flit[7:0] == 8'(exp_pos[ch] + 1));
          if (exp_pos[ch] == 0) begin
            check("r_fair", wait_pk[ch] <= CH, 1);
            wait_pk[ch] = 0;
          end
          if (bus.out_last) begin
            owner = -1;
            exp_pos[ch] = 0;
            exp_pkt[ch]++;
            for (int c = 0; c < CH; c++) begin
              if (c != ch && pos[c] == 0 && vld[c]) wait_pk[c]++;
            end
          end else begin
            owner = ch;
            exp_pos[ch]++;
          end
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (bus.in_ready[c] && vld[c]) begin
          if (pos[c] == len[c] - 1) begin
            pos[c] = 0;
            pkt[c]++;
            len[c] = 1 + $urandom_range(0, 3);
            vld[c] = 1'b0;
          end else begin
            pos[c]++;
          end
        end
      end
      @(negedge clk);
    end
    check("r_progress", ntx > 500, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
